// File: rtl/bw_io_impctl_pkg.sv
// rtl/bw_io_impctl_pkg.sv - shared FSM state type and default constants for the impedance up/down calibrator
package bw_io_impctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_ADJUST = 2'd3
    } cal_state_e;

    localparam int         DEF_CODE_W     = 8;
    localparam logic [7:0] DEF_CODE_INIT  = 8'h80;
    localparam int         DEF_SETTLE_CYC = 16;
    localparam int         DEF_FILT_N     = 4;
    localparam int         DEF_LOCK_TOG   = 3;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bw_io_impctl_sync2.sv
// rtl/bw_io_impctl_sync2.sv - two-flop synchronizer for one asynchronous bit
module bw_io_impctl_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bw_io_impctl_updn_cal.sv
// rtl/bw_io_impctl_updn_cal.sv - pull-up code up/down calibrator; IMPCTL_LOCK_HYST_EN adds post-lock step hysteresis
module bw_io_impctl_updn_cal
    import bw_io_impctl_pkg::*;
#(
    parameter int                CODE_W     = DEF_CODE_W,
    parameter logic [CODE_W-1:0] CODE_INIT  = DEF_CODE_INIT,
    parameter int                SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int                FILT_N     = DEF_FILT_N,
    parameter int                LOCK_TOG   = DEF_LOCK_TOG
) (
    input  logic              clk,
    input  logic              global_reset_n,
    input  logic              cal_en,
    input  logic              sclk,
    input  logic              abvref,
    output logic [CODE_W-1:0] cbu,
    output logic              above,
    output logic              locked,
    output logic              sat
);

    localparam int SET_W = cnt_w(SETTLE_CYC);
    localparam int RUN_W = cnt_w(FILT_N);
    localparam int TOG_W = cnt_w(LOCK_TOG);

    logic sclk_s;
    logic abv_s;

    bw_io_impctl_sync2 u_sync_sclk (
        .clk   (clk),
        .rst_n (global_reset_n),
        .d_i   (sclk),
        .q_o   (sclk_s)
    );

    bw_io_impctl_sync2 u_sync_abv (
        .clk   (clk),
        .rst_n (global_reset_n),
        .d_i   (abvref),
        .q_o   (abv_s)
    );

    cal_state_e        state_q, state_d;
    logic [CODE_W-1:0] cbu_q, cbu_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [TOG_W-1:0]  tog_q, tog_d;
    logic              above_q, above_d;
    logic              locked_q, locked_d;
    logic              sat_q, sat_d;
    logic              sclk_prev_q;
    logic              last_q, last_d;
    logic              prev_dir_q, prev_dir_d;
    logic              has_prev_q, has_prev_d;
`ifdef IMPCTL_LOCK_HYST_EN
    logic              pend_q, pend_d;
    logic              pend_dir_q, pend_dir_d;
`endif

    logic             sample_evt;
    logic [RUN_W-1:0] run_n;
    logic [TOG_W-1:0] tog_n;
    logic             dn;
    logic             step_req;
    logic             blocked;

    assign sample_evt = sclk_s & ~sclk_prev_q;

    // Next-state: settle timer, run-length filter on samples, one-cycle saturating code step.
    always_comb begin
        state_d    = state_q;
        cbu_d      = cbu_q;
        settle_d   = settle_q;
        run_d      = run_q;
        tog_d      = tog_q;
        above_d    = above_q;
        locked_d   = locked_q;
        sat_d      = sat_q;
        last_d     = last_q;
        prev_dir_d = prev_dir_q;
        has_prev_d = has_prev_q;
`ifdef IMPCTL_LOCK_HYST_EN
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
`endif
        run_n    = '0;
        tog_n    = '0;
        dn       = above_q;
        step_req = 1'b1;
        blocked  = 1'b0;

        if (!cal_en) begin
            // Dropping the enable abandons the calibration but keeps the code in use.
            state_d    = ST_IDLE;
            settle_d   = '0;
            run_d      = '0;
            tog_d      = '0;
            locked_d   = 1'b0;
            has_prev_d = 1'b0;
`ifdef IMPCTL_LOCK_HYST_EN
            pend_d     = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
                ST_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                        state_d  = ST_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (sample_evt) begin
                        run_n  = (run_q != '0 && abv_s == last_q) ? run_q + 1'b1 : RUN_W'(1);
                        last_d = abv_s;
                        if (run_n == RUN_W'(FILT_N)) begin
                            above_d = abv_s;
                            run_d   = '0;
                            state_d = ST_ADJUST;
                        end else begin
                            run_d = run_n;
                        end
                    end
                end
                ST_ADJUST: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
`ifdef IMPCTL_LOCK_HYST_EN
                    // Once locked, only two agreeing decisions in a row move the code.
                    if (locked_q) begin
                        if (pend_q && pend_dir_q == dn) begin
                            pend_d = 1'b0;
                        end else begin
                            step_req   = 1'b0;
                            pend_d     = 1'b1;
                            pend_dir_d = dn;
                        end
                    end
`endif
                    if (step_req) begin
                        blocked = dn ? (cbu_q == '0) : (cbu_q == '1);
                        if (blocked) begin
                            sat_d = 1'b1;
                            tog_n = '0;
                        end else begin
                            cbu_d = dn ? cbu_q - 1'b1 : cbu_q + 1'b1;
                            sat_d = 1'b0;
                            if (has_prev_q && prev_dir_q != dn) begin
                                tog_n = (tog_q == TOG_W'(LOCK_TOG)) ? tog_q : tog_q + 1'b1;
                            end else begin
                                tog_n = '0;
                            end
                        end
                        tog_d      = tog_n;
                        prev_dir_d = dn;
                        has_prev_d = 1'b1;
                        if (tog_n == TOG_W'(LOCK_TOG)) begin
                            locked_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q     <= ST_IDLE;
            cbu_q       <= CODE_INIT;
            settle_q    <= '0;
            run_q       <= '0;
            tog_q       <= '0;
            above_q     <= 1'b0;
            locked_q    <= 1'b0;
            sat_q       <= 1'b0;
            sclk_prev_q <= 1'b0;
            last_q      <= 1'b0;
            prev_dir_q  <= 1'b0;
            has_prev_q  <= 1'b0;
`ifdef IMPCTL_LOCK_HYST_EN
            pend_q      <= 1'b0;
            pend_dir_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cbu_q       <= cbu_d;
            settle_q    <= settle_d;
            run_q       <= run_d;
            tog_q       <= tog_d;
            above_q     <= above_d;
            locked_q    <= locked_d;
            sat_q       <= sat_d;
            sclk_prev_q <= sclk_s;
            last_q      <= last_d;
            prev_dir_q  <= prev_dir_d;
            has_prev_q  <= has_prev_d;
`ifdef IMPCTL_LOCK_HYST_EN
            pend_q      <= pend_d;
            pend_dir_q  <= pend_dir_d;
`endif
        end
    end

    assign cbu    = cbu_q;
    assign above  = above_q;
    assign locked = locked_q;
    assign sat    = sat_q;

endmodule

// File: doc/bw_io_impctl_updn_cal.md
BW_IO_IMPCTL_UPDN_CAL -- requirements
Module: bw_io_impctl_updn_cal

Interface
REQ-001 SHALL have parameter CODE_W, default 8: width of the pull-up drive code.
REQ-002 SHALL have parameter CODE_INIT, default 8'h80: code value at reset.
REQ-003 SHALL have parameter SETTLE_CYC, default 16: number of clk cycles to wait after each code change.
REQ-004 SHALL have parameter FILT_N, default 4: number of consecutive identical comparator samples needed for a decision.
REQ-005 SHALL have parameter LOCK_TOG, default 3: number of consecutive direction reversals that declares lock.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port global_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port cal_en, input, 1 bit: level enable for calibration.
REQ-009 SHALL have port sclk, input, 1 bit: asynchronous sample strobe.
REQ-010 SHALL have port abvref, input, 1 bit: asynchronous comparator output, 1 = pad above vref.
REQ-011 SHALL have port cbu, output, CODE_W bits: pull-up drive code.
REQ-012 SHALL have port above, output, 1 bit: last filtered comparator decision.
REQ-013 SHALL have port locked, output, 1 bit: calibration converged.
REQ-014 SHALL have port sat, output, 1 bit: code is pinned at 0 or at all-ones.

Function
REQ-015 SHALL pass sclk and abvref each through a 2-flop synchronizer; a sample event is a rising edge on the synchronized sclk.
REQ-016 SHALL implement FSM states IDLE, SETTLE, SAMPLE, ADJUST, with reset state IDLE.
REQ-017 IDLE: cbu held; transitions to SETTLE on the first cycle cal_en=1.
REQ-018 SETTLE: counts SETTLE_CYC clk cycles; sample events are ignored; then transitions to SAMPLE.
REQ-019 SAMPLE: on each sample event, captures synchronized abvref.
- Sample equal to the previous sample: run counter increments.
- Sample different: run counter reloads to 1.
- Run counter reaches FILT_N: above updates and the FSM transitions to ADJUST.
REQ-020 ADJUST lasts exactly one cycle.
- above=1: cbu decrements.
- above=0: cbu increments.
- Then transitions to SETTLE.
REQ-021 SHALL saturate cbu at 0 and at 2^CODE_W-1 with no wrap; a blocked step leaves cbu unchanged, sets sat, and clears the toggle counter.
REQ-022 SHALL clear sat on any successful step.
REQ-023 SHALL increment the toggle counter when a step direction differs from the previous step, and clear it otherwise.
REQ-024 SHALL set locked when the toggle counter reaches LOCK_TOG; locked stays 1 while cal_en=1.
REQ-025 SHALL, when cal_en falls in any state, enter IDLE next cycle, clear locked, the run counter and the toggle counter, and hold cbu, above and sat.
REQ-026 SHALL ignore a sample event coinciding with the SAMPLE-to-ADJUST transition.
REQ-027 SHALL keep the cbu change latency at sample event + 1 cycle in ADJUST, with cbu registered.

Reset
REQ-028 SHALL, on global_reset_n=0, asynchronously set cbu=CODE_INIT, above=0, locked=0, sat=0, state=IDLE, clear all counters and clear the synchronizers.
REQ-029 SHALL release reset on the clk edge, and an in-progress calibration SHALL restart from IDLE.

Configuration
REQ-030 With IMPCTL_LOCK_HYST_EN defined, once locked=1 the block SHALL step cbu only after two consecutive ADJUST decisions in the same direction; alternating decisions leave cbu unchanged.
REQ-031 Without IMPCTL_LOCK_HYST_EN, every ADJUST decision SHALL step cbu regardless of locked.

Structure
REQ-032 SHALL place the FSM state enum and the default parameter constants in shared package bw_io_impctl_pkg.
REQ-033 SHALL use one sub-module, bw_io_impctl_sync2 (2-flop synchronizer), instantiated twice.

Verification
REQ-034 Reset check: assert reset mid-SAMPLE -> cbu=8'h80, locked=0, sat=0, state IDLE immediately (asynchronous).
REQ-035 Filtering check: cal_en=1, abvref=0 held for 4 sample events -> cbu=8'h81 one cycle after the 4th event; then no further change for 16 cycles.
REQ-036 Glitch rejection: samples 0,0,1,0,0,0,0 -> exactly one increment, occurring after the 7th event.
REQ-037 Saturation: CODE_INIT=8'hFE, abvref=0 -> 8'hFF, then sat=1 and cbu stays 8'hFF.
REQ-038 Lock: alternate filtered decisions up/down/up/down -> locked=1 after the 3rd reversal; cal_en=0 -> locked=0 and cbu held.
REQ-039 Hysteresis: with IMPCTL_LOCK_HYST_EN, after lock, one dn then one up -> cbu unchanged; two dn -> cbu decrements once.
